// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped switch input port:
// IO word addresses decoded by the read mux and the per-bit debounce states.
package io_pkg;

    localparam logic [3:0] IO_ADDR_SWITCH = 4'h4;
    localparam logic [3:0] IO_ADDR_SWCHG  = 4'h5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } deb_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, then a two-state debounce FSM.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive cycles of
// disagreement between the synchronised input and the stable bit; any cycle
// of agreement in between restarts the count from nothing.
module debounce_bit
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic din,
    output logic stable,
    output logic change
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          s1_reg;
    logic          s2_reg;
    deb_state_t    state_reg,  state_next;
    logic [CW-1:0] cnt_reg,    cnt_next;
    logic          stable_reg, stable_next;
    logic          change_reg, change_next;
    logic          mismatch;

    // Bring the asynchronous switch level into the clock domain.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
        end
    end

    // Debounce state, counter, stable level and change pulse registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            change_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            change_reg <= change_next;
        end
    end

    assign mismatch = (s2_reg != stable_reg);

    // Next-state logic: count mismatching cycles, accept on the last one.
    // Completion clears the counter, so it never needs to wrap.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        change_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mismatch) begin
                    state_next = COUNT;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            COUNT: begin
                if (!mismatch) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    stable_next = s2_reg;
                    change_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign stable = stable_reg;
    assign change = change_reg;

endmodule

// File: rtl/io_switch_in.sv
// Debounced switch input port on the processor IO read bus.
// Word 4 reads the debounced switch levels; word 5 reads sticky change
// flags that clear when read with IOReadEn.
// Build option: define IO_SWITCH_CHANGE_EN to implement the change flags;
// without it word 5 reads zero and IOReadEn has no effect.
module io_switch_in
    import io_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] SWITCHES,
    input  logic [3:0]       IOAddr,
    input  logic             IOReadEn,
    output logic [31:0]      IOReadData,
    output logic [WIDTH-1:0] SW_STABLE,
    output logic [WIDTH-1:0] SW_CHANGE
);

    logic [WIDTH-1:0] chg_flags;

    // One independent debouncer per switch.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .CLK    (CLK),
                .RESET_N(RESET_N),
                .din    (SWITCHES[gi]),
                .stable (SW_STABLE[gi]),
                .change (SW_CHANGE[gi])
            );
        end
    endgenerate

`ifdef IO_SWITCH_CHANGE_EN
    logic [WIDTH-1:0] chg_flags_reg, chg_flags_next;
    logic             flag_clear;

    assign flag_clear = IOReadEn && (IOAddr == IO_ADDR_SWCHG);

    // Sticky flags: a clearing read drops old bits, a same-cycle change wins.
    always_comb begin
        chg_flags_next = chg_flags_reg;
        if (flag_clear) begin
            chg_flags_next = '0;
        end
        chg_flags_next = chg_flags_next | SW_CHANGE;
    end

    // Change flag register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            chg_flags_reg <= '0;
        end else begin
            chg_flags_reg <= chg_flags_next;
        end
    end

    assign chg_flags = chg_flags_reg;
`else
    logic unused_ioreaden;

    assign unused_ioreaden = IOReadEn;
    assign chg_flags       = '0;
`endif

    // Combinational read mux so data is valid in the cycle of the load.
    always_comb begin
        IOReadData = 32'h0;
        case (IOAddr)
            IO_ADDR_SWITCH: IOReadData = 32'(SW_STABLE);
            IO_ADDR_SWCHG:  IOReadData = 32'(chg_flags);
            default:        IOReadData = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_io_switch_in.sv
// Self-checking bench for io_switch_in with WIDTH=2, DEBOUNCE_CYCLES=4.
// A run-length model predicts stable/change/flags/read data every cycle;
// directed literal checks pin the key scenarios.
module tb_io_switch_in;

    localparam int W = 2;
    localparam int D = 4;

    logic          CLK;
    logic          RESET_N;
    logic [W-1:0]  SWITCHES;
    logic [3:0]    IOAddr;
    logic          IOReadEn;
    logic [31:0]   IOReadData;
    logic [W-1:0]  SW_STABLE;
    logic [W-1:0]  SW_CHANGE;

    int total = 0;
    int bad   = 0;

`ifdef IO_SWITCH_CHANGE_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    io_switch_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .SWITCHES  (SWITCHES),
        .IOAddr    (IOAddr),
        .IOReadEn  (IOReadEn),
        .IOReadData(IOReadData),
        .SW_STABLE (SW_STABLE),
        .SW_CHANGE (SW_CHANGE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // Raw level is delayed two edges; a bit flips once its delayed level has
    // disagreed with the stable level on D consecutive edges.
    logic [W-1:0] m_s1, m_s2, m_stable, m_change, m_flags;
    int           m_run [W];

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_change <= '0; m_flags <= '0;
            for (int b = 0; b < W; b++) m_run[b] <= 0;
        end else begin
            m_s1 <= SWITCHES;
            m_s2 <= m_s1;
            for (int b = 0; b < W; b++) begin
                if (m_s2[b] != m_stable[b]) begin
                    if (m_run[b] + 1 == D) begin
                        m_stable[b] <= m_s2[b];
                        m_change[b] <= 1'b1;
                        m_run[b]    <= 0;
                    end else begin
                        m_change[b] <= 1'b0;
                        m_run[b]    <= m_run[b] + 1;
                    end
                end else begin
                    m_change[b] <= 1'b0;
                    m_run[b]    <= 0;
                end
            end
            if (FLAGS_ON)
                m_flags <= ((IOReadEn && IOAddr == 4'h5) ? '0 : m_flags) | m_change;
        end
    end

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a == 4'h4) return 32'(m_stable);
        if (a == 4'h5) return FLAGS_ON ? 32'(m_flags) : 32'h0;
        return 32'h0;
    endfunction

    // Per-cycle compare, away from the active edge.
    always @(negedge CLK) begin
        total++;
        if (SW_STABLE !== m_stable) begin
            bad++;
            $display("FAIL model_stable t=%0t got=%b want=%b", $time, SW_STABLE, m_stable);
        end
        total++;
        if (SW_CHANGE !== m_change) begin
            bad++;
            $display("FAIL model_change t=%0t got=%b want=%b", $time, SW_CHANGE, m_change);
        end
        total++;
        if (IOReadData !== model_read(IOAddr)) begin
            bad++;
            $display("FAIL model_read t=%0t addr=%h got=%h want=%h", $time, IOAddr,
                     IOReadData, model_read(IOAddr));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("ok   %s = %h", name, got);
        end
    endtask

    int pulses;
    bit seen;

    initial begin
        RESET_N  = 1'b0;
        SWITCHES = 2'b11;
        IOAddr   = 4'h0;
        IOReadEn = 1'b0;

        // Reset held with switches high: everything reads zero.
        tick(3);
        chk("reset_stable", 32'(SW_STABLE), 32'h0);
        chk("reset_change", 32'(SW_CHANGE), 32'h0);
        IOAddr = 4'h4; #1;
        chk("reset_rd4", IOReadData, 32'h0);
        IOAddr = 4'h5; IOReadEn = 1'b1; #1;
        chk("reset_rd5", IOReadData, 32'h0);
        IOReadEn = 1'b0; IOAddr = 4'h4;

        // Release: first edge captures the level, stable follows 5 edges later.
        RESET_N = 1'b1;
        tick(5);
        chk("release_edge4_stable", 32'(SW_STABLE), 32'h0);
        tick(1);
        chk("release_edge5_stable", 32'(SW_STABLE), 32'h3);
        chk("release_edge5_change", 32'(SW_CHANGE), 32'h3);
        tick(1);
        chk("release_change_drop", 32'(SW_CHANGE), 32'h0);

        // Back to 00, then clear flags.
        SWITCHES = 2'b00;
        tick(10);
        chk("back_to_00", 32'(SW_STABLE), 32'h0);
        IOAddr = 4'h5; IOReadEn = 1'b1; #1;
        chk("flags_after_11_00", IOReadData, FLAGS_ON ? 32'h3 : 32'h0);
        tick(1);
        IOReadEn = 1'b0; IOAddr = 4'h4;

        // Clean change 00 -> 01.
        SWITCHES = 2'b01;
        pulses = 0;
        tick(5);
        chk("clean_edge4_rd4", IOReadData, 32'h0);
        if (SW_CHANGE[0]) pulses++;
        tick(1);
        chk("clean_edge5_rd4", IOReadData, 32'h1);
        for (int i = 0; i < 8; i++) begin
            if (SW_CHANGE[0]) pulses++;
            tick(1);
        end
        chk("clean_pulse_count", 32'(pulses), 32'h1);
        chk("clean_held_rd4", IOReadData, 32'h1);

        // Flag clear by read.
        IOAddr = 4'h5; IOReadEn = 1'b1; #1;
        chk("flag_read1", IOReadData, FLAGS_ON ? 32'h1 : 32'h0);
        tick(1);
        #1;
        chk("flag_read2", IOReadData, 32'h0);
        IOReadEn = 1'b0;

        // Bounce: bit1 high for 3 cycles only.
        pulses = 0;
        SWITCHES = 2'b11;
        tick(3);
        SWITCHES = 2'b01;
        for (int i = 0; i < 10; i++) begin
            if (SW_CHANGE != 0) pulses++;
            tick(1);
        end
        chk("bounce_no_change", 32'(pulses), 32'h0);
        chk("bounce_stable", 32'(SW_STABLE), 32'h1);
        IOAddr = 4'h5; #1;
        chk("bounce_flags", IOReadData, 32'h0);

        // Collision: flags hold 01, read-clear lands on the SW_CHANGE[1] cycle.
        SWITCHES = 2'b00;
        tick(10);
        SWITCHES = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (SW_CHANGE[1]) seen = 1'b1;
        end
        chk("collision_wait", 32'(seen), 32'h1);
        #1;
        IOAddr = 4'h5; IOReadEn = 1'b1; #1;
        chk("collision_read_old", IOReadData, FLAGS_ON ? 32'h1 : 32'h0);
        tick(1);
        IOReadEn = 1'b0; #1;
        chk("collision_bit1_kept", IOReadData, FLAGS_ON ? 32'h2 : 32'h0);
        IOReadEn = 1'b1;
        tick(1);
        IOReadEn = 1'b0;

        // Unmapped and switch addresses.
        IOAddr = 4'h9; #1;
        chk("unmapped_rd9", IOReadData, 32'h0);
        IOAddr = 4'h4; #1;
        chk("rd4_value_10", IOReadData, 32'h2);

        // Reset mid-count aborts, then the held level is re-debounced.
        SWITCHES = 2'b11;
        tick(3);
        RESET_N = 1'b0; #1;
        chk("midcount_reset_stable", 32'(SW_STABLE), 32'h0);
        tick(2);
        RESET_N = 1'b1;
        tick(4);
        chk("rearm_not_yet", 32'(SW_STABLE), 32'h0);
        tick(6);
        chk("rearm_stable", 32'(SW_STABLE), 32'h3);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
